// File: rtl/msg_buffer.sv
// Message-granular egress buffer: stores parser beats speculatively and releases a
// message through a registered valid/ready port only once its End beat is stored.
module msg_buffer #(
    parameter int WordWidth = 64,
    parameter int LogWidth  = 3,
    parameter int Depth     = 16,
    parameter int AddrBits  = 4
) (
    input  logic                 msg_buffer_clk,
    input  logic                 msg_buffer_reset,
    input  logic                 msg_buffer_in_valid,
    input  logic                 msg_buffer_in_start,
    input  logic                 msg_buffer_in_end,
    input  logic [LogWidth-1:0]  msg_buffer_in_mod,
    input  logic [WordWidth-1:0] msg_buffer_in_data,
    output logic                 msg_buffer_out_valid,
    input  logic                 msg_buffer_out_ready,
    output logic                 msg_buffer_out_start,
    output logic                 msg_buffer_out_end,
    output logic [LogWidth-1:0]  msg_buffer_out_mod,
    output logic [WordWidth-1:0] msg_buffer_out_data,
    output logic                 msg_buffer_full,
    output logic [15:0]          msg_buffer_drop_count
);

    localparam int PW = AddrBits + 1;
    localparam int EW = WordWidth + LogWidth + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(Depth);

    logic [EW-1:0]        mem_q [Depth];
    logic [PW-1:0]        wr_q, wr_d;
    logic [PW-1:0]        cm_q, cm_d;
    logic [PW-1:0]        rd_q, rd_d;
    logic                 in_msg_q, in_msg_d;
    logic                 dropping_q, dropping_d;
    logic [15:0]          drop_q;
    logic [1:0]           drop_inc;
    logic                 we;
    logic [PW-1:0]        waddr;
    logic [PW-1:0]        base;
    logic [PW-1:0]        occ_base;
    logic [PW-1:0]        occ_cur;
    logic [PW-1:0]        occ_next;
    logic                 ld;
    logic [EW-1:0]        rd_entry;

    logic                 out_valid_q;
    logic                 out_start_q;
    logic                 out_end_q;
    logic [LogWidth-1:0]  out_mod_q;
    logic [WordWidth-1:0] out_data_q;
    logic                 full_q;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Write side: speculative storage, rewinding to the last commit point on discard.
    always_comb begin
        wr_d       = wr_q;
        cm_d       = cm_q;
        in_msg_d   = in_msg_q;
        dropping_d = dropping_q;
        drop_inc   = 2'd0;
        we         = 1'b0;
        waddr      = wr_q;
        base       = in_msg_q ? cm_q : wr_q;
        occ_base   = base - rd_q;
        occ_cur    = wr_q - rd_q;
        if (msg_buffer_in_valid) begin
            if (msg_buffer_in_start) begin
                if (in_msg_q) begin
                    drop_inc = 2'd1;
                end
                if (occ_base < DEPTH_P) begin
                    we         = 1'b1;
                    waddr      = base;
                    wr_d       = base + 1'b1;
                    in_msg_d   = ~msg_buffer_in_end;
                    dropping_d = 1'b0;
                    if (msg_buffer_in_end) begin
                        cm_d = base + 1'b1;
                    end
                end else begin
                    // A start&end beat that cannot fit is a complete, dropped message.
                    wr_d       = base;
                    drop_inc   = drop_inc + 2'd1;
                    in_msg_d   = ~msg_buffer_in_end;
                    dropping_d = ~msg_buffer_in_end;
                end
            end else if (in_msg_q) begin
                if (dropping_q) begin
                    if (msg_buffer_in_end) begin
                        in_msg_d   = 1'b0;
                        dropping_d = 1'b0;
                    end
                end else if (occ_cur < DEPTH_P) begin
                    we    = 1'b1;
                    waddr = wr_q;
                    wr_d  = wr_q + 1'b1;
                    if (msg_buffer_in_end) begin
                        cm_d     = wr_q + 1'b1;
                        in_msg_d = 1'b0;
                    end
                end else begin
                    wr_d       = cm_q;
                    drop_inc   = 2'd1;
                    in_msg_d   = ~msg_buffer_in_end;
                    dropping_d = ~msg_buffer_in_end;
                end
            end
        end
    end

    // Read side: only committed entries (below cm_ptr) are ever loaded into the output stage.
    always_comb begin
        ld       = (rd_q != cm_q) && (!out_valid_q || msg_buffer_out_ready);
        rd_d     = ld ? rd_q + 1'b1 : rd_q;
        rd_entry = mem_q[rd_q[AddrBits-1:0]];
        occ_next = wr_d - rd_d;
    end

    always_ff @(posedge msg_buffer_clk) begin
        if (we) begin
            mem_q[waddr[AddrBits-1:0]] <= {msg_buffer_in_start, msg_buffer_in_end,
                                           msg_buffer_in_mod, msg_buffer_in_data};
        end
    end

    always_ff @(posedge msg_buffer_clk) begin
        if (msg_buffer_reset) begin
            wr_q        <= '0;
            cm_q        <= '0;
            rd_q        <= '0;
            in_msg_q    <= 1'b0;
            dropping_q  <= 1'b0;
            drop_q      <= 16'd0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_mod_q   <= '0;
            out_data_q  <= '0;
        end else begin
            wr_q       <= wr_d;
            cm_q       <= cm_d;
            rd_q       <= rd_d;
            in_msg_q   <= in_msg_d;
            dropping_q <= dropping_d;
            drop_q     <= sat_add16(drop_q, drop_inc);
            full_q     <= (occ_next == DEPTH_P);
            if (ld) begin
                out_valid_q <= 1'b1;
                out_start_q <= rd_entry[EW-1];
                out_end_q   <= rd_entry[EW-2];
                out_mod_q   <= rd_entry[WordWidth +: LogWidth];
                out_data_q  <= rd_entry[WordWidth-1:0];
            end else begin
                out_valid_q <= out_valid_q & ~msg_buffer_out_ready;
            end
        end
    end

    assign msg_buffer_out_valid  = out_valid_q;
    assign msg_buffer_out_start  = out_start_q;
    assign msg_buffer_out_end    = out_end_q;
    assign msg_buffer_out_mod    = out_mod_q;
    assign msg_buffer_out_data   = out_data_q;
    assign msg_buffer_full       = full_q;
    assign msg_buffer_drop_count = drop_q;

endmodule
